// File: rtl/text_buffer_arbiter.sv
// text_buffer_arbiter
//   Owns the character buffer read by the text engine and shares its single
//   write port between two requesters (A and B) with req/ack round-robin
//   arbitration. After reset, or on a clearReq pulse, the whole buffer is
//   filled with CLEAR_CHAR, one entry per cycle.
//
// Ports
//   clk          clock, all state changes on posedge
//   resetn       synchronous active-low reset
//   charAddress  text-engine read address
//   charOutput   mem[charAddress], combinational (old byte until the write edge)
//   wrReqA/B     write request, held until the matching ack
//   wrAddrA/B    write address, stable while the request is high
//   wrDataA/B    write data, stable while the request is high
//   wrAckA/B     the requester's write commits at this clock edge
//   clearReq     one-cycle pulse that starts a full clear (ignored while busy)
//   busy         clear in progress (also high while resetn is low)
module text_buffer_arbiter #(
    parameter int         ADDR_W     = 6,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] charAddress,
    output logic [7:0]        charOutput,
    input  logic              wrReqA,
    input  logic [ADDR_W-1:0] wrAddrA,
    input  logic [7:0]        wrDataA,
    output logic              wrAckA,
    input  logic              wrReqB,
    input  logic [ADDR_W-1:0] wrAddrB,
    input  logic [7:0]        wrDataB,
    output logic              wrAckB,
    input  logic              clearReq,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clrIdx;
    logic              lastGrant;   // 0 = A was granted last, 1 = B

    logic [7:0]        mem [DEPTH];

    logic              arbOpen;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [7:0]        wrData;

    assign charOutput = mem[charAddress];

    assign busy = !resetn || (state == CLEAR);

    // Arbitration is only open in IDLE with no clear being requested;
    // a clear request always beats pending writes.
    assign arbOpen = resetn && (state == IDLE) && !clearReq;

    // On contention the requester that was not granted last wins.
    always_comb begin
        wrAckA = 1'b0;
        wrAckB = 1'b0;
        if (arbOpen) begin
            if (wrReqA && wrReqB) begin
                wrAckA = lastGrant;
                wrAckB = !lastGrant;
            end else begin
                wrAckA = wrReqA;
                wrAckB = wrReqB;
            end
        end
    end

    // Single write port: clear sweep or the granted requester.
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = '0;
        if (resetn && state == CLEAR) begin
            wrEn   = 1'b1;
            wrAddr = clrIdx;
            wrData = CLEAR_CHAR;
        end else if (wrAckA) begin
            wrEn   = 1'b1;
            wrAddr = wrAddrA;
            wrData = wrDataA;
        end else if (wrAckB) begin
            wrEn   = 1'b1;
            wrAddr = wrAddrB;
            wrData = wrDataB;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= CLEAR;
            clrIdx    <= '0;
            lastGrant <= 1'b1;  // A wins the first tie
        end else begin
            case (state)
                CLEAR: begin
                    clrIdx <= clrIdx + 1'b1;
                    if (clrIdx == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (clearReq) begin
                        state  <= CLEAR;
                        clrIdx <= '0;
                    end else if (wrAckA) begin
                        lastGrant <= 1'b0;
                    end else if (wrAckB) begin
                        lastGrant <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Bench for text_buffer_arbiter: a buffer-level model (array of bytes, count
// of clear cycles left, who was served last) checked against the DUT on every
// negedge, plus directed scenarios with hand-computed expectations.
module tb_text_buffer_arbiter;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [ADDR_W-1:0] charAddress = '0;
    logic [7:0]        charOutput;
    logic              wrReqA = 1'b0;
    logic [ADDR_W-1:0] wrAddrA = '0;
    logic [7:0]        wrDataA = '0;
    logic              wrAckA;
    logic              wrReqB = 1'b0;
    logic [ADDR_W-1:0] wrAddrB = '0;
    logic [7:0]        wrDataB = '0;
    logic              wrAckB;
    logic              clearReq = 1'b0;
    logic              busy;

    int errors = 0;
    int checks = 0;

    text_buffer_arbiter #(.ADDR_W(ADDR_W), .CLEAR_CHAR(8'h20)) dut (
        .clk(clk), .resetn(resetn),
        .charAddress(charAddress), .charOutput(charOutput),
        .wrReqA(wrReqA), .wrAddrA(wrAddrA), .wrDataA(wrDataA), .wrAckA(wrAckA),
        .wrReqB(wrReqB), .wrAddrB(wrAddrB), .wrDataB(wrDataB), .wrAckB(wrAckB),
        .clearReq(clearReq), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] modelMem [DEPTH];
    int         clearLeft = 0;   // clear cycles still to run
    int         clearPos  = 0;   // next entry the clear will overwrite
    bit         servedB   = 1'b1;
    bit         modelOn   = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) modelMem[i] = 8'hxx;
    end

    // Who gets the write port this cycle: 0 nobody, 1 A, 2 B.
    function automatic int winner();
        if (!resetn || clearLeft > 0 || clearReq) return 0;
        if (wrReqA && wrReqB) return servedB ? 1 : 2;
        if (wrReqA) return 1;
        if (wrReqB) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        int w;
        w = winner();
        if (!resetn) begin
            clearLeft = DEPTH;
            clearPos  = 0;
            servedB   = 1'b1;
            modelOn   = 1'b1;
        end else if (clearLeft > 0) begin
            modelMem[clearPos] = 8'h20;
            clearPos  = clearPos + 1;
            clearLeft = clearLeft - 1;
        end else if (clearReq) begin
            clearLeft = DEPTH;
            clearPos  = 0;
        end else if (w == 1) begin
            modelMem[wrAddrA] = wrDataA;
            servedB = 1'b0;
        end else if (w == 2) begin
            modelMem[wrAddrB] = wrDataB;
            servedB = 1'b1;
        end
    end

    always @(negedge clk) begin
        int w;
        if (modelOn) begin
            w = winner();
            check("busy", 32'(busy), 32'(!resetn || clearLeft > 0));
            check("wrAckA", 32'(wrAckA), 32'(w == 1));
            check("wrAckB", 32'(wrAckB), 32'(w == 2));
            if (!$isunknown(modelMem[charAddress]))
                check("charOutput", 32'(charOutput), 32'(modelMem[charAddress]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitClear(input string name, input int expCycles);
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'(expCycles));
    endtask

    initial begin
        logic [3:0] ackLog;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_acks", 32'({wrAckA, wrAckB}), 32'd0);

        // 1: clear after reset, every entry reads as space
        resetn = 1'b1;
        waitClear("t1_clear_len", 64);
        for (int i = 0; i < DEPTH; i++) begin
            charAddress = ADDR_W'(i);
            #1;
            check("t1_space", 32'(charOutput), 32'h20);
        end

        // 2: single A write, visible next cycle
        wrReqA = 1'b1; wrAddrA = 6'd5; wrDataA = 8'h41;
        #1;
        check("t2_ackA", 32'(wrAckA), 32'd1);
        tick();
        wrReqA = 1'b0;
        charAddress = 6'd5;
        #1;
        check("t2_read", 32'(charOutput), 32'h41);

        // 3: reset, then A and B contend for 4 cycles
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        waitClear("t3_clear_len", 64);
        wrReqA = 1'b1; wrAddrA = 6'd10; wrDataA = 8'hA0;
        wrReqB = 1'b1; wrAddrB = 6'd11; wrDataB = 8'hB0;
        for (int k = 0; k < 4; k++) begin
            #1;
            ackLog[k] = wrAckB;
            check("t3_one_ack", 32'(wrAckA ^ wrAckB), 32'd1);
            tick();
            if (ackLog[k]) wrDataB = wrDataB + 8'h01;
            else           wrDataA = wrDataA + 8'h01;
        end
        wrReqA = 1'b0; wrReqB = 1'b0;
        check("t3_order", 32'(ackLog), 32'b1010);
        charAddress = 6'd10;
        #1;
        check("t3_lastA", 32'(charOutput), 32'hA1);
        charAddress = 6'd11;
        #1;
        check("t3_lastB", 32'(charOutput), 32'hB1);

        // 4: clear beats a pending A write
        clearReq = 1'b1;
        wrReqA = 1'b1; wrAddrA = 6'd20; wrDataA = 8'h55;
        #1;
        check("t4_no_ack", 32'(wrAckA), 32'd0);
        tick();
        clearReq = 1'b0;
        waitClear("t4_clear_len", 64);
        check("t4_ackA", 32'(wrAckA), 32'd1);
        tick();
        wrReqA = 1'b0;
        charAddress = 6'd20;
        #1;
        check("t4_data", 32'(charOutput), 32'h55);
        charAddress = 6'd10;
        #1;
        check("t4_cleared", 32'(charOutput), 32'h20);

        // 5: reset mid-clear restarts it; clearReq during clear is ignored
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        repeat (30) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        begin
            int n;
            n = 0;
            while (busy && n < 300) begin
                clearReq = (n == 10);
                tick();
                n++;
            end
            clearReq = 1'b0;
            check("t5_clear_len", 32'(n), 32'd64);
        end

        // 6: B writes 63 while it is being read
        charAddress = 6'd63;
        wrReqB = 1'b1; wrAddrB = 6'd63; wrDataB = 8'h7E;
        #1;
        check("t6_ackB", 32'(wrAckB), 32'd1);
        check("t6_old", 32'(charOutput), 32'h20);
        tick();
        wrReqB = 1'b0;
        #1;
        check("t6_new", 32'(charOutput), 32'h7E);

        // withdrawn request writes nothing: raise and drop A during a clear
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        wrReqA = 1'b1; wrAddrA = 6'd3; wrDataA = 8'h99;
        tick();
        wrReqA = 1'b0;
        waitClear("t7_clear_len", 63);
        charAddress = 6'd3;
        #1;
        check("t7_withdrawn", 32'(charOutput), 32'h20);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
